// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction prefetch buffer between a single-outstanding instruction memory
// and the fetch/decode stage. A small request FSM walks fetch_pc forward by one
// word per returned instruction and parks the {pc, ir} pairs in a 4-entry FIFO.
// A redirect from execute flushes the FIFO and restarts fetch at redirect_pc.
// A request that is still in flight when the redirect arrives is drained and
// its data is dropped.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   redirect         flush queue and restart fetch at redirect_pc
//   redirect_pc      restart address (bits [1:0] ignored)
//   mem_req          request valid, held until mem_ack
//   mem_addr         word-aligned request address, held until mem_ack
//   mem_ack          memory returns mem_rdata for the outstanding request
//   mem_rdata        returned instruction word
//   out_valid        FIFO head available
//   out_pc, out_ir   FIFO head contents (0x00000000 / NOP when empty)
//   out_ready        consumer accepts the head this cycle
//   stall            blocks pops only
// -----------------------------------------------------------------------------
module fetch_prefetch_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir,
    input  logic        out_ready,
    input  logic        stall
);

    localparam logic [31:0] NOP_IR = 32'h0000_0013;
    localparam logic [2:0]  DEPTH  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;

    logic [31:0] pc_mem_q [4];
    logic [31:0] ir_mem_q [4];

    logic        pop;
    logic        push;
    logic [2:0]  count_after;
    logic [31:0] redirect_target;

    // Redirect outranks both pop and push.
    assign pop  = (count_q != 3'd0) && out_ready && !stall && !redirect;
    // Data is only kept for a live request; a full queue without a
    // simultaneous pop never receives a push.
    assign push = (state_q == ST_WAIT) && mem_ack && !redirect &&
                  ((count_q < DEPTH) || pop);

    assign count_after     = count_q + {2'b00, push} - {2'b00, pop};
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                // mem_ack here has no matching request and is ignored.
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (count_q < DEPTH) begin
                    state_d    = ST_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end

            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    // Without the ack the request is still in flight and must
                    // be drained before a new one may be issued.
                    state_d    = mem_ack ? ST_IDLE : ST_DISCARD;
                    mem_req_d  = !mem_ack;
                end else if (mem_ack) begin
                    fetch_pc_d = mem_addr_q + 32'd4;
                    if (count_after < DEPTH) begin
                        // Back-to-back issue: the next request goes out
                        // directly, without a pass through IDLE.
                        mem_addr_d = mem_addr_q + 32'd4;
                    end else begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end

            ST_DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d  = count_after;
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        wr_ptr_d = wr_ptr_q + {1'b0, push};
        if (redirect) begin
            count_d  = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= 3'd0;
            fetch_pc_q <= 32'h0000_0000;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0000_0000;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: the entry storage has no reset; an entry is only observed while
    // count covers it, and the empty-queue outputs are forced below.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q] <= mem_addr_q;
            ir_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = (count_q != 3'd0);
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign out_ir    = out_valid ? ir_mem_q[rd_ptr_q] : NOP_IR;

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: redirect  input  1  taken branch/jump from execute; flush queue and restart fetch.
REQ-005 Port: redirect_pc  input  32  restart address, sampled when redirect=1.
REQ-006 Port: mem_req  output  1  instruction-memory request valid.
REQ-007 Port: mem_addr  output  32  word-aligned fetch address, held stable while mem_req=1.
REQ-008 Port: mem_ack  input  1  memory returns data this cycle for the outstanding request.
REQ-009 Port: mem_rdata  input  32  instruction word, valid only when mem_ack=1.
REQ-010 Port: out_valid  output  1  head entry available to fetch stage.
REQ-011 Port: out_pc  output  32  PC of head entry.
REQ-012 Port: out_ir  output  32  instruction of head entry.
REQ-013 Port: out_ready  input  1  fetch/decode can accept the head entry.
REQ-014 Port: stall  input  1  external fetch stall; blocks pops only.

Function
REQ-015 The queue SHALL hold 4 entries of {pc[31:0], ir[31:0]} in FIFO order, with a 3-bit occupancy count (0..4).
REQ-016 The block SHALL hold a fetch_pc register; increments by 4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-017 The request FSM SHALL have states IDLE (mem_req=0), WAIT (mem_req=1, request outstanding), DISCARD (mem_req=1, outstanding request to be dropped).
REQ-018 At most one memory request SHALL be outstanding; mem_req and mem_addr SHALL stay unchanged from issue until the mem_ack cycle.
REQ-019 IDLE -> WAIT when count<4 and redirect=0; mem_addr<=fetch_pc; mem_req registered, first high the following cycle.
REQ-020 WAIT with mem_ack=1 and redirect=0: push {mem_addr, mem_rdata}; fetch_pc<=mem_addr+4; stay WAIT with mem_addr<=mem_addr+4 if post-push/pop count<4, else IDLE.
REQ-021 Pop SHALL occur when out_valid=1, out_ready=1, stall=0; push and pop in the same cycle leave count unchanged and SHALL be legal at count=4.
REQ-022 out_valid SHALL equal (count!=0); when count=0 out_pc=0x00000000, out_ir=0x00000013 (NOP).
REQ-023 redirect=1 SHALL take priority over push and pop: count<=0, fetch_pc<=redirect_pc with bits[1:0] forced to 00; out_valid=0 the next cycle.
REQ-024 redirect in IDLE -> IDLE; issue from the new fetch_pc per REQ-019.
REQ-025 redirect in WAIT with mem_ack=0 -> DISCARD; redirect in WAIT/DISCARD with mem_ack=1 -> IDLE, returned data dropped.
REQ-026 DISCARD with mem_ack=1 and redirect=0 SHALL drop mem_rdata, push nothing and go IDLE.
REQ-027 A redirect in DISCARD SHALL overwrite fetch_pc again; only the latest redirect_pc is used.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 Minimum latency: redirect at cycle N -> mem_req=1 with new address at N+2 -> entry visible on out_* the cycle after mem_ack.

Reset
REQ-030 While rst_n=0: state=IDLE, count=0, fetch_pc=0x00000000, mem_req=0, mem_addr=0x00000000, out_valid=0, out_pc=0x00000000, out_ir=0x00000013.
REQ-031 Reset assertion mid-request SHALL abandon the outstanding request; a mem_ack arriving after release while IDLE is ignored per REQ-028.
REQ-032 First request after reset release SHALL target 0x00000000.

Verification
REQ-033 Reset release, mem_ack one cycle after each mem_req, out_ready=1 -> addresses 0x0,0x4,0x8 in order; out_pc/out_ir match, no gaps after warm-up.
REQ-034 out_ready=0, continuous ack -> exactly 4 pushes (pc 0x0..0xC), then mem_req=0 and count=4; raise out_ready -> pops in order, fetch resumes at 0x10.
REQ-035 Redirect to 0x00000103 while WAIT, ack 3 cycles later with 0xDEADBEEF -> data dropped, out_valid=0, next mem_addr=0x00000100.
REQ-036 Redirect with simultaneous mem_ack and pop at count=2 -> count=0, no push, next request to redirect_pc.
REQ-037 stall=1, out_ready=1, count=4 -> no pops, no pushes, out_pc frozen; release stall -> one pop per cycle.
REQ-038 fetch_pc forced via redirect to 0xFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; also rst_n=0 mid-WAIT -> all REQ-030 values immediately.
